serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Parametrised multi-bit subtractor computing d = x - y - bin over WIDTH bits. It works LSB-first, BPC bits per clock, through a chain of full-subtractor cells with a registered borrow between chunks. A start/busy/done handshake frames each operation. It is the sequential, width-generic successor to the single-bit full subtractor, for datapaths that trade latency for area.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥2.
BPC, 1, bits processed per clock; must divide WIDTH evenly; WIDTH==BPC gives single-pass operation.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge
x  input  WIDTH  minuend; captured when start is accepted
y  input  WIDTH  subtrahend; captured when start is accepted
bin  input  1  borrow-in; captured when start is accepted
d  output  WIDTH  difference, registered
bout  output  1  borrow-out of the MSB, registered
ovf  output  1  two's-complement signed overflow flag, registered
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse marking that d/bout/ovf are valid

Behaviour:
- Reset (async, rst=1): state IDLE; d=0, bout=0, ovf=0, busy=0, done=0; internal operand, borrow and chunk counter cleared. Reset mid-operation discards the operation; no done pulse follows.
- States: IDLE and RUN.
- IDLE with start=1 at edge T0:
  - capture x, y and bin into internal registers (borrow register = bin), chunk counter = 0;
  - go to RUN; busy=1 from T0.
- RUN, each edge: process bits [k*BPC +: BPC], k = counter.
  - Per bit: di = xi ^ yi ^ b; b_next = (~xi & yi) | (~(xi ^ yi) & b).
  - Borrow ripples inside the chunk; the final borrow is registered for the next chunk.
  - Result bits are written into the d shift/accumulate register. d may change during RUN and is valid only at and after done.
- Last chunk at edge TN, where N = WIDTH/BPC:
  - bout = final borrow;
  - ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]), using the captured x and y. bin does not enter the ovf equation;
  - state returns to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: done high in the cycle following edge TN, N cycles after the start edge. Throughput: one operation per N+1 cycles when start is held high.
- start while busy=1: ignored. The captured operands are not disturbed and no queueing occurs.
- start=1 in the cycle done=1 (state IDLE): accepted normally. d/bout/ovf keep the old result until the new operation overwrites them.
- Result hold: d, bout and ovf keep their last values in IDLE until the next accepted start or a reset.
- Inputs x, y and bin may change freely after the start edge without affecting the result.
- Unsigned interpretation: bout=1 exactly when x < y + bin. Signed interpretation: ovf flags an out-of-range result.

Test Plan:
- WIDTH=8, BPC=1: start with x=0x05, y=0x03, bin=0 -> busy for 8 cycles; done pulses on cycle 8 after start; d=0x02, bout=0, ovf=0.
- WIDTH=8: x=0x00, y=0x01, bin=0 -> d=0xFF, bout=1, ovf=0. Then x=0x80, y=0x01 -> d=0x7F, bout=0, ovf=1. Then x=0x10, y=0x0F, bin=1 -> d=0x00, bout=0.
- WIDTH=8: start x=0x20, y=0x10; on cycle 3 assert start with x=0xFF, y=0x00 -> second request ignored; result d=0x10, single done pulse, busy falls after 8 cycles.
- WIDTH=8: start x=0xAA, y=0x55, then assert rst during cycle 4 -> immediately d=0, bout=0, busy=0; no done pulse. After release, a new start with x=0x03, y=0x01 -> d=0x02.
- WIDTH=8, BPC=4: x=0x3C, y=0x4D, bin=0 -> done 2 cycles after start; d=0xEF, bout=1, ovf=0. Start held high -> back-to-back operations every 3 cycles.
- WIDTH=4, BPC=2, exhaustive: iterate {x,y,bin} over all 512 combinations, each run to completion -> {bout,d} equals (x - y - bin) mod 32 with bit 4 as the borrow, and ovf matches the signed-range check on every case.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor d = x - y - bin, LSB-first, BPC bits per clock.
// A registered borrow links successive chunks; start/busy/done frames each operation.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             x_msb;
    logic             y_msb;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load;
    logic             step;
    logic             last;
    logic [BPC:0]     chunk;
    logic [WIDTH-1:0] diff_top;

    // Ripple of BPC full-subtractor cells; returns {borrow_out, diff}.
    function automatic logic [BPC:0] sub_chunk(
        input logic [BPC-1:0] a,
        input logic [BPC-1:0] b,
        input logic           bi
    );
        logic [BPC-1:0] dv;
        logic           br;
        br = bi;
        dv = '0;
        for (int i = 0; i < BPC; i++) begin
            dv[i] = a[i] ^ b[i] ^ br;
            br    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        return {br, dv};
    endfunction

    // Signed overflow: operands of opposite sign and result sign differs from minuend.
    function automatic logic sub_ovf(input logic xm, input logic ym, input logic dm);
        return (xm != ym) && (dm != xm);
    endfunction

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = (cnt_q == CNT_W'(N - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Current chunk always sits in the low bits of the shifting operand registers.
    always_comb begin
        chunk    = sub_chunk(x_sh[BPC-1:0], y_sh[BPC-1:0], brw_q);
        diff_top = WIDTH'(chunk[BPC-1:0]) << (WIDTH - BPC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh  <= '0;
            y_sh  <= '0;
            x_msb <= 1'b0;
            y_msb <= 1'b0;
            brw_q <= 1'b0;
            cnt_q <= '0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= step && last;
            if (load) begin
                x_sh  <= x;
                y_sh  <= y;
                x_msb <= x[WIDTH-1];
                y_msb <= y[WIDTH-1];
                brw_q <= bin;
                cnt_q <= '0;
            end else if (step) begin
                x_sh  <= x_sh >> BPC;
                y_sh  <= y_sh >> BPC;
                brw_q <= chunk[BPC];
                cnt_q <= cnt_q + CNT_W'(1);
                // Result enters at the top and drifts down; after N chunks it is aligned.
                d     <= (d >> BPC) | diff_top;
                if (last) begin
                    bout <= chunk[BPC];
                    ovf  <= sub_ovf(x_msb, y_msb, chunk[BPC-1]);
                end
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule
